// File: rtl/code_check_pkg.sv
// Shared types and sizes for the code_check entry verifier.
package code_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_UNLOCK  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam int KEY_W      = 8;
    localparam int MAX_KEYS   = 4;
    localparam int NUM_KEYS_W = 4;
    localparam int TMR_W      = 16;

    // Entry length is the stored key count limited to the key register depth.
    function automatic logic [2:0] clamp_len(input logic [NUM_KEYS_W-1:0] n);
        if (n > NUM_KEYS_W'(MAX_KEYS)) begin
            clamp_len = 3'(MAX_KEYS);
        end else begin
            clamp_len = n[2:0];
        end
    endfunction

endpackage

// File: rtl/code_check_cycle_timer.sv
// Loadable down-counter with zero flag; shared by unlock, lockout and entry timeout.
module cycle_timer
    import code_check_pkg::*;
(
    input  logic             dclk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            r_count <= {TMR_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {TMR_W{1'b0}})) begin
            r_count <= r_count - {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {TMR_W{1'b0}});

endmodule

// File: rtl/code_check.sv
// Key-sequence verifier with unlock hold, failure counting and timed lockout.
// Optional entry inactivity timeout is enabled by defining CODE_CHECK_TIMEOUT_EN.
module code_check
    import code_check_pkg::*;
#(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int UNLOCK_CYCLES  = 500,
    parameter int LOCKOUT_CYCLES = 1000
`ifdef CODE_CHECK_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 2000
`endif
)
(
    input  logic                  dclk,
    input  logic                  reset,
    input  logic [KEY_W-1:0]      din,
    input  logic                  dvalid,
    input  logic [31:0]           keys,
    input  logic [NUM_KEYS_W-1:0] num_keys,
    output logic                  unlocked,
    output logic                  fail,
    output logic                  lockout,
    output logic [3:0]            attempts,
    output logic                  busy
);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic             r_mis, w_mis_nxt;
    logic [2:0]       r_len, w_len_nxt;
    logic [3:0]       w_att_nxt, w_att_inc;
    logic             w_fail_nxt;
    logic             w_decide, w_dec_mis;
    logic             w_tmr_load, w_tmr_en, w_tmr_zero;
    logic [TMR_W-1:0] w_tmr_val;
    logic [KEY_W-1:0] w_key;
    logic             w_is_last;

    assign w_key     = keys[{r_idx, 3'b000} +: KEY_W];
    assign w_is_last = ({1'b0, r_idx} == (r_len - 3'd1));
    assign w_att_inc = (attempts < 4'(MAX_ATTEMPTS)) ? (attempts + 4'd1) : attempts;

    cycle_timer u_timer (
        .dclk       (dclk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    // Next-state, datapath and timer control.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mis_nxt   = r_mis;
        w_len_nxt   = r_len;
        w_att_nxt   = attempts;
        w_fail_nxt  = 1'b0;
        w_decide    = 1'b0;
        w_dec_mis   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_en    = 1'b0;
        w_tmr_val   = {TMR_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (dvalid && (num_keys != 4'd0)) begin
                    w_len_nxt = clamp_len(num_keys);
                    w_idx_nxt = 2'd0;
                    w_mis_nxt = (din != keys[KEY_W-1:0]);
                    if (w_len_nxt == 3'd1) begin
                        w_decide  = 1'b1;
                        w_dec_mis = w_mis_nxt;
                    end else begin
                        w_idx_nxt   = 2'd1;
                        w_state_nxt = ST_ENTRY;
`ifdef CODE_CHECK_TIMEOUT_EN
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (dvalid) begin
                    w_mis_nxt = r_mis | (din != w_key);
                    if (w_is_last) begin
                        w_decide  = 1'b1;
                        w_dec_mis = w_mis_nxt;
                    end else begin
                        w_idx_nxt  = r_idx + 2'd1;
`ifdef CODE_CHECK_TIMEOUT_EN
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end else begin
`ifdef CODE_CHECK_TIMEOUT_EN
                    // Abandoned partial entry: silent return, attempts untouched.
                    if (w_tmr_zero) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
`else
                    w_state_nxt = ST_ENTRY;
`endif
                end
            end
            ST_UNLOCK: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (w_tmr_zero) begin
                    w_state_nxt = ST_IDLE;
                    w_att_nxt   = 4'd0;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_decide) begin
            if (!w_dec_mis) begin
                w_state_nxt = ST_UNLOCK;
                w_att_nxt   = 4'd0;
                w_tmr_load  = 1'b1;
                w_tmr_val   = TMR_W'(UNLOCK_CYCLES - 1);
            end else begin
                w_fail_nxt = 1'b1;
                w_att_nxt  = w_att_inc;
                if (w_att_inc == 4'(MAX_ATTEMPTS)) begin
                    w_state_nxt = ST_LOCKOUT;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TMR_W'(LOCKOUT_CYCLES - 1);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        end else begin
            w_fail_nxt = 1'b0;
        end
    end

    // State, datapath and registered outputs aligned with the next state.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 2'd0;
            r_mis    <= 1'b0;
            r_len    <= 3'd0;
            attempts <= 4'd0;
            fail     <= 1'b0;
            unlocked <= 1'b0;
            lockout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_mis    <= w_mis_nxt;
            r_len    <= w_len_nxt;
            attempts <= w_att_nxt;
            fail     <= w_fail_nxt;
            unlocked <= (w_state_nxt == ST_UNLOCK);
            lockout  <= (w_state_nxt == ST_LOCKOUT);
            busy     <= (w_state_nxt == ST_ENTRY);
        end
    end

endmodule

// File: tb/tb_code_check.sv
// Directed bench for code_check; timeout steps run when CODE_CHECK_TIMEOUT_EN is defined.
module tb_code_check;

    logic       dclk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       dvalid;
    logic [31:0] keys;
    logic [3:0] num_keys;
    logic       unlocked, fail, lockout, busy;
    logic [3:0] attempts;

    int vectors = 0;
    int miscompares = 0;

    always #5 dclk = ~dclk;

`ifdef CODE_CHECK_TIMEOUT_EN
    code_check #(.TIMEOUT_CYCLES(20)) dut (
`else
    code_check dut (
`endif
        .dclk(dclk), .reset(reset), .din(din), .dvalid(dvalid),
        .keys(keys), .num_keys(num_keys), .unlocked(unlocked), .fail(fail),
        .lockout(lockout), .attempts(attempts), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic u, input logic f,
                              input logic l, input logic b, input logic [3:0] a);
        check({tag, ".unlocked"}, {31'd0, unlocked}, {31'd0, u});
        check({tag, ".fail"},     {31'd0, fail},     {31'd0, f});
        check({tag, ".lockout"},  {31'd0, lockout},  {31'd0, l});
        check({tag, ".busy"},     {31'd0, busy},     {31'd0, b});
        check({tag, ".attempts"}, {28'd0, attempts}, {28'd0, a});
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge dclk);
        din = b;
        dvalid = 1'b1;
        @(negedge dclk);
        dvalid = 1'b0;
        din = 8'h00;
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        send(b0); send(b1); send(b2); send(b3);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge dclk);
    endtask

    initial begin
        reset = 1'b1; din = 8'h00; dvalid = 1'b0;
        keys = 32'h44332211; num_keys = 4'd4;
        wait_cycles(2);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        wait_cycles(1);

        // Correct 4-byte code
        send(8'h11); send(8'h22); send(8'h33);
        check_outs("ok_partial", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        send(8'h44);
        check_outs("ok_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cycles(499);
        check("unlock_last_cycle", {31'd0, unlocked}, 32'd1);
        wait_cycles(1);
        check("unlock_released", {31'd0, unlocked}, 32'd0);

        // Wrong second byte: verdict only after the 4th byte
        send(8'h11); send(8'h99); send(8'h33);
        check_outs("bad_no_early", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        send(8'h44);
        check_outs("bad1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        wait_cycles(1);
        check_outs("bad1_pulse_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        // Two more failures trigger lockout
        send4(8'h00, 8'h00, 8'h00, 8'h00);
        check_outs("bad2", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        send4(8'h11, 8'h22, 8'h33, 8'h45);
        check_outs("bad3_lock", 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        check_outs("lock_ignores", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        wait_cycles(991);
        check("lock_last_cycle", {31'd0, lockout}, 32'd1);
        wait_cycles(1);
        check_outs("lock_released", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        send4(8'h11, 8'h22, 8'h33, 8'h44);
        check_outs("post_lock_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cycles(500);

        // No stored keys: input ignored
        num_keys = 4'd0;
        send(8'h11); send(8'h11);
        check_outs("no_keys", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // Length latched at first byte
        keys = 32'h4433BBAA; num_keys = 4'd2;
        send(8'hAA);
        check_outs("len_latch_busy", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        num_keys = 4'd4;
        send(8'hBB);
        check_outs("len_latch_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cycles(500);

        // Asynchronous reset mid-entry with a nonzero attempt count
        keys = 32'h44332211;
        send4(8'h11, 8'h22, 8'h33, 8'h00);
        check("pre_reset_attempts", {28'd0, attempts}, 32'd1);
        send(8'h11); send(8'h22);
        #2 reset = 1'b1;
        #1 check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge dclk);
        reset = 1'b0;

        // num_keys above 4 behaves as 4
        num_keys = 4'd15;
        send(8'h11); send(8'h22); send(8'h33);
        check_outs("nk15_partial", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        send(8'h44);
        check_outs("nk15_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cycles(500);

        // Single-key code decides on the first byte
        num_keys = 4'd1;
        send(8'h11);
        check_outs("len1_unlock", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cycles(500);
        send(8'h5A);
        check_outs("len1_fail", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);

`ifdef CODE_CHECK_TIMEOUT_EN
        // Partial entry abandoned after 20 idle cycles
        num_keys = 4'd4;
        send(8'h11);
        wait_cycles(19);
        check_outs("timeout_pending", 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        wait_cycles(1);
        check_outs("timeout_abort", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
